// File: rtl/wrired_seq.sv
// Command sequencer for the 4x1-bit bit-serial store: expands nibble/single-bit
// read/write commands into per-bit memory beats and returns one response each.
module wrired_seq (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       CMD_VALID,
    output logic       CMD_READY,
    input  logic       CMD_WR,
    input  logic       CMD_ALL,
    input  logic [1:0] CMD_ADDR,
    input  logic [3:0] CMD_DATA,
    output logic [1:0] MEM_ADDR,
    output logic       MEM_IN,
    output logic       MEM_RW,
    input  logic       MEM_OUT,
    output logic       RSP_VALID,
    input  logic       RSP_READY,
    output logic       RSP_WR,
    output logic [3:0] RSP_DATA
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} state_t;

    state_t     state, state_nxt;
    logic [1:0] k, k_nxt;
    logic       wr_q, wr_nxt;
    logic       all_q, all_nxt;
    logic [1:0] addr_q, addr_nxt;
    logic [3:0] data_q, data_nxt;

    logic [1:0] mem_addr_nxt;
    logic       mem_in_nxt;
    logic       mem_rw_nxt;
    logic       rsp_valid_nxt;
    logic       rsp_wr_nxt;
    logic [3:0] rsp_data_nxt;
    logic [1:0] beat_addr;
    logic       last_beat;

    assign CMD_READY = (state == IDLE);

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state     <= IDLE;
            k         <= '0;
            wr_q      <= 1'b0;
            all_q     <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            MEM_ADDR  <= '0;
            MEM_IN    <= 1'b0;
            MEM_RW    <= 1'b0;
            RSP_VALID <= 1'b0;
            RSP_WR    <= 1'b0;
            RSP_DATA  <= '0;
        end else begin
            state     <= state_nxt;
            k         <= k_nxt;
            wr_q      <= wr_nxt;
            all_q     <= all_nxt;
            addr_q    <= addr_nxt;
            data_q    <= data_nxt;
            MEM_ADDR  <= mem_addr_nxt;
            MEM_IN    <= mem_in_nxt;
            MEM_RW    <= mem_rw_nxt;
            RSP_VALID <= rsp_valid_nxt;
            RSP_WR    <= rsp_wr_nxt;
            RSP_DATA  <= rsp_data_nxt;
        end
    end

    // Memory outputs are registered, so each beat is computed one cycle ahead:
    // beat 0 is loaded on the accept edge, beat k+1 while beat k is on the bus.
    always_comb begin
        state_nxt     = state;
        k_nxt         = k;
        wr_nxt        = wr_q;
        all_nxt       = all_q;
        addr_nxt      = addr_q;
        data_nxt      = data_q;
        mem_addr_nxt  = '0;
        mem_in_nxt    = 1'b0;
        mem_rw_nxt    = 1'b0;
        rsp_valid_nxt = RSP_VALID;
        rsp_wr_nxt    = RSP_WR;
        rsp_data_nxt  = RSP_DATA;
        beat_addr     = '0;
        last_beat     = 1'b0;

        case (state)
            IDLE: begin
                if (CMD_VALID) begin
                    state_nxt    = ISSUE;
                    k_nxt        = '0;
                    wr_nxt       = CMD_WR;
                    all_nxt      = CMD_ALL;
                    addr_nxt     = CMD_ADDR;
                    data_nxt     = CMD_DATA;
                    rsp_wr_nxt   = CMD_WR;
                    rsp_data_nxt = '0;
                    beat_addr    = CMD_ALL ? 2'd0 : CMD_ADDR;
                    mem_addr_nxt = beat_addr;
                    mem_rw_nxt   = CMD_WR;
                    mem_in_nxt   = CMD_WR & CMD_DATA[beat_addr];
                end
            end

            ISSUE: begin
                last_beat = !all_q || (k == 2'd3);
                // Store OUT now reflects the previous nibble beat.
                if (!wr_q && (k != 2'd0)) begin
                    rsp_data_nxt[k - 2'd1] = MEM_OUT;
                end
                if (last_beat) begin
                    if (wr_q) begin
                        state_nxt     = RESP;
                        rsp_valid_nxt = 1'b1;
                    end else begin
                        state_nxt = DRAIN;
                    end
                end else begin
                    k_nxt        = k + 2'd1;
                    beat_addr    = k + 2'd1;
                    mem_addr_nxt = beat_addr;
                    mem_rw_nxt   = wr_q;
                    mem_in_nxt   = wr_q & data_q[beat_addr];
                end
            end

            DRAIN: begin
                beat_addr               = all_q ? 2'd3 : addr_q;
                rsp_data_nxt[beat_addr] = MEM_OUT;
                state_nxt               = RESP;
                rsp_valid_nxt           = 1'b1;
            end

            RESP: begin
                if (RSP_READY) begin
                    state_nxt     = IDLE;
                    rsp_valid_nxt = 1'b0;
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_wrired_seq.sv
// Directed bench for wrired_seq with a behavioural 4x1-bit store whose OUT is
// registered, driven by the sequencer's memory port.
module tb_wrired_seq;

    logic       CLK;
    logic       RST_N;
    logic       CMD_VALID;
    logic       CMD_READY;
    logic       CMD_WR;
    logic       CMD_ALL;
    logic [1:0] CMD_ADDR;
    logic [3:0] CMD_DATA;
    logic [1:0] MEM_ADDR;
    logic       MEM_IN;
    logic       MEM_RW;
    logic       MEM_OUT;
    logic       RSP_VALID;
    logic       RSP_READY;
    logic       RSP_WR;
    logic [3:0] RSP_DATA;

    int tests;
    int fails;
    int lat;

    logic store [4];

    wrired_seq dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .CMD_VALID (CMD_VALID),
        .CMD_READY (CMD_READY),
        .CMD_WR    (CMD_WR),
        .CMD_ALL   (CMD_ALL),
        .CMD_ADDR  (CMD_ADDR),
        .CMD_DATA  (CMD_DATA),
        .MEM_ADDR  (MEM_ADDR),
        .MEM_IN    (MEM_IN),
        .MEM_RW    (MEM_RW),
        .MEM_OUT   (MEM_OUT),
        .RSP_VALID (RSP_VALID),
        .RSP_READY (RSP_READY),
        .RSP_WR    (RSP_WR),
        .RSP_DATA  (RSP_DATA)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (MEM_RW) store[MEM_ADDR] <= MEM_IN;
        MEM_OUT <= store[MEM_ADDR];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic wr, input logic all, input logic [1:0] addr, input logic [3:0] data);
        chk("cmd_ready_before_accept", 32'(CMD_READY), 1);
        CMD_VALID = 1'b1;
        CMD_WR    = wr;
        CMD_ALL   = all;
        CMD_ADDR  = addr;
        CMD_DATA  = data;
        step();
        CMD_VALID = 1'b0;
    endtask

    // lat = cycles after the accept edge at which RSP_VALID is first seen.
    task automatic wait_rsp(output int cyc);
        cyc = 1;
        while (!RSP_VALID && cyc < 20) begin
            step();
            cyc++;
        end
    endtask

    task automatic pop();
        RSP_READY = 1'b1;
        step();
        RSP_READY = 1'b0;
        chk("rsp_valid_after_pop", 32'(RSP_VALID), 0);
    endtask

    task automatic txn(input string tag, input logic wr, input logic all, input logic [1:0] addr,
                       input logic [3:0] data, input int exp_lat, input logic [3:0] exp_data);
        int l;
        send(wr, all, addr, data);
        wait_rsp(l);
        chk({tag, "_latency"}, 32'(l), 32'(exp_lat));
        chk({tag, "_rsp_data"}, 32'(RSP_DATA), 32'(exp_data));
        chk({tag, "_rsp_wr"}, 32'(RSP_WR), 32'(wr));
        pop();
    endtask

    initial begin
        logic [3:0] wdat;
        tests     = 0;
        fails     = 0;
        RST_N     = 1'b0;
        CMD_VALID = 1'b0;
        CMD_WR    = 1'b0;
        CMD_ALL   = 1'b0;
        CMD_ADDR  = '0;
        CMD_DATA  = '0;
        RSP_READY = 1'b0;

        step();
        step();
        chk("rst_cmd_ready", 32'(CMD_READY), 1);
        chk("rst_mem_addr", 32'(MEM_ADDR), 0);
        chk("rst_mem_in", 32'(MEM_IN), 0);
        chk("rst_mem_rw", 32'(MEM_RW), 0);
        chk("rst_rsp_valid", 32'(RSP_VALID), 0);
        chk("rst_rsp_wr", 32'(RSP_WR), 0);
        chk("rst_rsp_data", 32'(RSP_DATA), 0);
        RST_N = 1'b1;
        step();

        // Nibble write 1011: four write beats then response at N+5.
        wdat = 4'b1011;
        send(1'b1, 1'b1, 2'd0, wdat);
        for (int i = 0; i < 4; i++) begin
            chk("wr_beat_rw", 32'(MEM_RW), 1);
            chk("wr_beat_addr", 32'(MEM_ADDR), 32'(i));
            chk("wr_beat_in", 32'(MEM_IN), 32'(wdat[i]));
            chk("wr_beat_no_rsp", 32'(RSP_VALID), 0);
            step();
        end
        chk("wr_after_rw", 32'(MEM_RW), 0);
        chk("wr_rsp_valid_n5", 32'(RSP_VALID), 1);
        chk("wr_rsp_wr", 32'(RSP_WR), 1);
        chk("wr_rsp_data", 32'(RSP_DATA), 0);
        pop();

        txn("nib_rd_1011", 1'b0, 1'b1, 2'd0, 4'b0000, 6, 4'b1011);
        txn("single_wr_a2", 1'b1, 1'b0, 2'd2, 4'b0100, 2, 4'b0000);
        txn("single_rd_a2", 1'b0, 1'b0, 2'd2, 4'b1111, 3, 4'b0100);

        // Response stall with a competing command that must not be accepted.
        send(1'b0, 1'b1, 2'd0, 4'b0000);
        wait_rsp(lat);
        chk("hold_latency", 32'(lat), 6);
        CMD_VALID = 1'b1;
        CMD_WR    = 1'b1;
        CMD_ALL   = 1'b1;
        CMD_DATA  = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            chk("hold_rsp_valid", 32'(RSP_VALID), 1);
            chk("hold_rsp_data", 32'(RSP_DATA), 32'hF);
            chk("hold_cmd_ready", 32'(CMD_READY), 0);
            chk("hold_mem_rw", 32'(MEM_RW), 0);
            step();
        end
        pop();
        CMD_VALID = 1'b0;
        txn("after_hold_rd", 1'b0, 1'b1, 2'd0, 4'b0000, 6, 4'b1111);

        // Reset during beat 1 of a nibble write of 0000 over 1111.
        send(1'b1, 1'b1, 2'd0, 4'b0000);
        step();
        chk("abort_beat1_addr", 32'(MEM_ADDR), 1);
        RST_N = 1'b0;
        step();
        RST_N = 1'b1;
        chk("abort_cmd_ready", 32'(CMD_READY), 1);
        chk("abort_mem_rw", 32'(MEM_RW), 0);
        chk("abort_mem_addr", 32'(MEM_ADDR), 0);
        chk("abort_mem_in", 32'(MEM_IN), 0);
        chk("abort_rsp_valid", 32'(RSP_VALID), 0);
        chk("abort_rsp_data", 32'(RSP_DATA), 0);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("abort_no_rsp", 32'(RSP_VALID), 0);
        end
        txn("abort_rd", 1'b0, 1'b1, 2'd0, 4'b0000, 6, 4'b1100);

        // Back-to-back: command valid and response ready held high.
        RSP_READY = 1'b1;
        CMD_VALID = 1'b1;
        CMD_WR    = 1'b1;
        CMD_ALL   = 1'b1;
        CMD_DATA  = 4'b0110;
        step();
        CMD_WR   = 1'b0;
        CMD_DATA = 4'b1001;
        wait_rsp(lat);
        chk("b2b_wr_latency", 32'(lat), 5);
        chk("b2b_wr_rsp_wr", 32'(RSP_WR), 1);
        step();
        chk("b2b_popped", 32'(RSP_VALID), 0);
        chk("b2b_ready_after_pop", 32'(CMD_READY), 1);
        step();
        chk("b2b_second_accept", 32'(CMD_READY), 0);
        chk("b2b_rd_beat0_rw", 32'(MEM_RW), 0);
        CMD_VALID = 1'b0;
        RSP_READY = 1'b0;
        wait_rsp(lat);
        chk("b2b_rd_latency", 32'(lat), 6);
        chk("b2b_rd_data", 32'(RSP_DATA), 32'h6);
        chk("b2b_rd_rsp_wr", 32'(RSP_WR), 0);
        pop();

        txn("single_rd_a1", 1'b0, 1'b0, 2'd1, 4'b0000, 3, 4'b0010);
        txn("single_rd_a3", 1'b0, 1'b0, 2'd3, 4'b1111, 3, 4'b0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
